// File: rtl/operand_store_if.sv
// Store-request and write-port bundle between execute stage, operand_store and RAM/register file.
// slave: operand_store side; master: the requester and memories driving it.
interface operand_store_if #(
  parameter int MODE_WIDTH     = 2,
  parameter int OPERAND_WIDTH  = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int REG_DATA_WIDTH = 8
);
  logic                      start;
  logic [MODE_WIDTH-1:0]     mode;
  logic [OPERAND_WIDTH-1:0]  operand_in;
  logic [DATA_WIDTH-1:0]     data_in;
  logic [REG_DATA_WIDTH-1:0] reg_rdata;

  logic                      busy;
  logic                      done;
  logic                      error;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata;
  logic                      ram_we;
  logic [REG_ADDR_WIDTH-1:0] reg_addr;
  logic [REG_DATA_WIDTH-1:0] reg_wdata;
  logic                      reg_we;

  modport slave (
    input  start, mode, operand_in, data_in, reg_rdata,
    output busy, done, error, ram_addr, ram_wdata, ram_we, reg_addr, reg_wdata, reg_we
  );

  modport master (
    output start, mode, operand_in, data_in, reg_rdata,
    input  busy, done, error, ram_addr, ram_wdata, ram_we, reg_addr, reg_wdata, reg_we
  );
endinterface

// File: rtl/operand_store.sv
// Writes an 8-bit result to RAM or the register file using IMM/DIR/INDIR/REG destination modes.
// Latency from capture: IMM done +1, DIR/REG strobe +1 done +2, INDIR ptr +1 strobe +2 done +3; starts while busy are dropped.
module operand_store #(
  parameter int MODE_WIDTH     = 2,
  parameter int OPERAND_WIDTH  = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int REG_DATA_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  operand_store_if.slave     bus
);

  localparam logic [MODE_WIDTH-1:0] MODE_IMM   = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] MODE_DIR   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_INDIR = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] MODE_REG   = MODE_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [MODE_WIDTH-1:0]     mode_q,    mode_d;
  logic [OPERAND_WIDTH-1:0]  operand_q, operand_d;
  logic [DATA_WIDTH-1:0]     data_q,    data_d;
  logic [RAM_ADDR_WIDTH-1:0] ptr_q,     ptr_d;

  // Address/wdata outputs hold whatever was last driven, so each has a hold register.
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q,  reg_addr_d;
  logic [REG_DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;

  logic ram_we_d;
  logic reg_we_d;
  logic done_d;
  logic error_d;
  logic busy_d;

  logic [RAM_ADDR_WIDTH-1:0] op_ram_addr;
  logic [REG_ADDR_WIDTH-1:0] op_reg_addr;
  logic [RAM_DATA_WIDTH-1:0] data_ram;
  logic [REG_DATA_WIDTH-1:0] data_reg;

  assign op_ram_addr = RAM_ADDR_WIDTH'(operand_q);
  assign op_reg_addr = REG_ADDR_WIDTH'(operand_q);
  assign data_ram    = RAM_DATA_WIDTH'(data_q);
  assign data_reg    = REG_DATA_WIDTH'(data_q);

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      operand_q   <= '0;
      data_q      <= '0;
      ptr_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      operand_q   <= operand_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // Next-state and request capture.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    operand_d = operand_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          operand_d = bus.operand_in;
          data_d    = bus.data_in;
          if (bus.mode == MODE_IMM) begin
            state_d = S_DONE;
          end else if (bus.mode == MODE_INDIR) begin
            state_d = S_PTR;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_PTR: begin
        ptr_d   = RAM_ADDR_WIDTH'(bus.reg_rdata);
        state_d = S_WR;
      end
      S_WR: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: strobes only in WR, pointer read address in PTR, otherwise hold.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    ram_we_d    = 1'b0;
    reg_we_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    busy_d      = (state_q != S_IDLE);
    unique case (state_q)
      S_PTR: begin
        reg_addr_d = op_reg_addr;
      end
      S_WR: begin
        if (mode_q == MODE_DIR) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = op_ram_addr;
          ram_wdata_d = data_ram;
        end else if (mode_q == MODE_INDIR) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = ptr_q;
          ram_wdata_d = data_ram;
        end else if (mode_q == MODE_REG) begin
          reg_we_d    = 1'b1;
          reg_addr_d  = op_reg_addr;
          reg_wdata_d = data_reg;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        error_d = (mode_q == MODE_IMM);
      end
      default: begin
      end
    endcase
  end

  assign bus.busy      = busy_d;
  assign bus.done      = done_d;
  assign bus.error     = error_d;
  assign bus.ram_addr  = ram_addr_d;
  assign bus.ram_wdata = ram_wdata_d;
  assign bus.ram_we    = ram_we_d;
  assign bus.reg_addr  = reg_addr_d;
  assign bus.reg_wdata = reg_wdata_d;
  assign bus.reg_we    = reg_we_d;

endmodule

// File: tb/tb_operand_store.sv
// Directed bench for operand_store: reset, each destination mode, busy drop, reset mid-PTR.
module tb_operand_store;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  operand_store_if bus ();

  operand_store dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Register-file model: combinational read at the DUT's reg_addr.
  logic [7:0] rf [16];
  assign bus.reg_rdata = rf[bus.reg_addr];

  int checks = 0;
  int errors = 0;

  // Write/done monitor, sampled on the falling edge.
  int         ram_we_cnt = 0;
  int         reg_we_cnt = 0;
  int         done_cnt   = 0;
  int         both_we    = 0;
  logic [7:0] last_ram_addr = 8'h00;

  always @(negedge clk) begin
    if (bus.ram_we) begin
      ram_we_cnt++;
      last_ram_addr = bus.ram_addr;
    end
    if (bus.reg_we) reg_we_cnt++;
    if (bus.done) done_cnt++;
    if (bus.ram_we && bus.reg_we) both_we++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] m, input logic [7:0] op, input logic [7:0] d);
    bus.start      = 1'b1;
    bus.mode       = m;
    bus.operand_in = op;
    bus.data_in    = d;
  endtask

  task automatic scramble();
    bus.start      = 1'b0;
    bus.mode       = 2'b11;
    bus.operand_in = 8'hFF;
    bus.data_in    = 8'h00;
  endtask

  int ram0, reg0, done0;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rf[5]  = 8'h20;
    rf[15] = 8'h9E;

    // Reset held for two edges with a pending start.
    rst_n = 1'b0;
    req(2'b01, 8'h10, 8'hBB);
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_reg_we", bus.reg_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_reg_addr", bus.reg_addr, 0);
    chk("rst_reg_wdata", bus.reg_wdata, 0);
    chk("rst_no_write", ram_we_cnt + reg_we_cnt, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_busy", bus.busy, 0);

    // DIR store.
    req(2'b01, 8'h10, 8'hBB);
    step();
    scramble();
    chk("dir_ram_we", bus.ram_we, 1);
    chk("dir_ram_addr", bus.ram_addr, 8'h10);
    chk("dir_ram_wdata", bus.ram_wdata, 8'hBB);
    chk("dir_reg_we", bus.reg_we, 0);
    chk("dir_busy", bus.busy, 1);
    chk("dir_early_done", bus.done, 0);
    step();
    chk("dir_done", bus.done, 1);
    chk("dir_error", bus.error, 0);
    chk("dir_we_off", bus.ram_we, 0);
    chk("dir_addr_hold", bus.ram_addr, 8'h10);
    step();
    chk("dir_idle_busy", bus.busy, 0);
    chk("dir_idle_done", bus.done, 0);

    // INDIR store, with a DIR start issued while busy and held into DONE.
    ram0 = ram_we_cnt;
    req(2'b10, 8'h05, 8'hCC);
    step();
    chk("indir_ptr_reg_addr", bus.reg_addr, 4'h5);
    chk("indir_ptr_ram_we", bus.ram_we, 0);
    chk("indir_ptr_busy", bus.busy, 1);
    req(2'b01, 8'h30, 8'h77);
    step();
    chk("indir_ram_we", bus.ram_we, 1);
    chk("indir_ram_addr", bus.ram_addr, 8'h20);
    chk("indir_ram_wdata", bus.ram_wdata, 8'hCC);
    step();
    chk("indir_done", bus.done, 1);
    chk("indir_error", bus.error, 0);
    step();
    bus.start = 1'b0;
    chk("indir_start_in_done_dropped", bus.busy, 0);
    step();
    step();
    chk("indir_single_ram_we", ram_we_cnt - ram0, 1);
    chk("indir_last_addr", last_ram_addr, 8'h20);
    chk("indir_addr_hold", bus.ram_addr, 8'h20);

    // REG store: excess operand bits ignored.
    req(2'b11, 8'h17, 8'hDD);
    step();
    scramble();
    chk("reg_reg_we", bus.reg_we, 1);
    chk("reg_reg_addr", bus.reg_addr, 4'h7);
    chk("reg_reg_wdata", bus.reg_wdata, 8'hDD);
    chk("reg_ram_we", bus.ram_we, 0);
    step();
    chk("reg_done", bus.done, 1);
    chk("reg_error", bus.error, 0);
    chk("reg_we_off", bus.reg_we, 0);
    step();

    // IMM: illegal destination, error pulse, no strobe.
    ram0 = ram_we_cnt;
    reg0 = reg_we_cnt;
    req(2'b00, 8'hAA, 8'h11);
    step();
    scramble();
    chk("imm_done", bus.done, 1);
    chk("imm_error", bus.error, 1);
    chk("imm_busy", bus.busy, 1);
    // Start in the IDLE cycle straight after DONE is accepted.
    step();
    chk("imm_idle_busy", bus.busy, 0);
    chk("imm_no_write", (ram_we_cnt - ram0) + (reg_we_cnt - reg0), 0);
    req(2'b01, 8'h41, 8'h5A);
    step();
    scramble();
    chk("b2b_ram_we", bus.ram_we, 1);
    chk("b2b_ram_addr", bus.ram_addr, 8'h41);
    chk("b2b_ram_wdata", bus.ram_wdata, 8'h5A);
    step();
    step();

    // INDIR with operand upper bits set: pointer register 0xF.
    req(2'b10, 8'hAF, 8'h3C);
    step();
    scramble();
    chk("indir2_reg_addr", bus.reg_addr, 4'hF);
    step();
    chk("indir2_ram_addr", bus.ram_addr, 8'h9E);
    chk("indir2_ram_wdata", bus.ram_wdata, 8'h3C);
    step();
    chk("indir2_done", bus.done, 1);
    step();

    // Reset during PTR abandons the store.
    ram0  = ram_we_cnt;
    done0 = done_cnt;
    req(2'b10, 8'h05, 8'hE1);
    step();
    scramble();
    chk("rstmid_in_ptr", bus.reg_addr, 4'h5);
    rst_n = 1'b0;
    step();
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_ram_we", bus.ram_we, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_ram_addr_cleared", bus.ram_addr, 0);
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("rstmid_no_ram_we", ram_we_cnt - ram0, 0);
    chk("rstmid_no_done", done_cnt - done0, 0);
    chk("rstmid_idle", bus.busy, 0);

    chk("never_both_we", both_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_store.md
Name: operand_store

Overview:
- Destination-side counterpart of the operand fetch path: writes an 8-bit result back to its destination using the same 2-bit addressing modes (IMM, DIR, INDIR, REG).
- Sits between the execute stage and the RAM / register file write ports.
- Takes one store request per start pulse, runs a small FSM and gives a done/error pulse.
- INDIR costs one extra cycle to read the pointer register.

Parameters:
MODE_WIDTH, 2, addressing-mode field width (00 IMM, 01 DIR, 10 INDIR, 11 REG)
OPERAND_WIDTH, 8, operand field width
DATA_WIDTH, 8, result data width
RAM_ADDR_WIDTH, 8, RAM address width
RAM_DATA_WIDTH, 8, RAM write data width
REG_ADDR_WIDTH, 4, register-file address width
REG_DATA_WIDTH, 8, register-file data width

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  store request; sampled only in IDLE
mode  in  MODE_WIDTH  destination addressing mode, sampled with start
operand_in  in  OPERAND_WIDTH  address / register number, sampled with start
data_in  in  DATA_WIDTH  value to store, sampled with start
reg_rdata  in  REG_DATA_WIDTH  combinational register-file read data (pointer for INDIR)
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle completion pulse
error  out  1  high with done when mode was IMM (illegal destination)
ram_addr  out  RAM_ADDR_WIDTH  RAM write address
ram_wdata  out  RAM_DATA_WIDTH  RAM write data
ram_we  out  1  RAM write strobe, one cycle
reg_addr  out  REG_ADDR_WIDTH  register-file address (pointer read in PTR, write target in WR)
reg_wdata  out  REG_DATA_WIDTH  register write data
reg_we  out  1  register write strobe, one cycle

Behaviour:
- Interface timing: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE.
  - All outputs go to 0.
  - Latched mode, operand and data are cleared.
- Reset mid-operation: the pending write is abandoned. No strobe is asserted after the reset edge, and no done pulse is given.
- Start capture: when start=1 in IDLE, latch mode, operand_in and data_in. Then:
  - DIR or REG: go to WR.
  - INDIR: go to PTR.
  - IMM: go to DONE with error set.
- Busy behaviour: start while busy is ignored; the request is lost, with no queueing. Inputs may change freely after the capture edge.
- PTR (one cycle):
  - reg_addr = operand[REG_ADDR_WIDTH-1:0].
  - At the end of the cycle, latch reg_rdata as the pointer: truncated or zero-extended to RAM_ADDR_WIDTH.
  - Go to WR.
- WR (one cycle): exactly one strobe is high.
  - DIR: ram_we=1, ram_addr = operand[RAM_ADDR_WIDTH-1:0], ram_wdata = data.
  - INDIR: ram_we=1, ram_addr = latched pointer, ram_wdata = data.
  - REG: reg_we=1, reg_addr = operand[REG_ADDR_WIDTH-1:0], reg_wdata = data.
  - Go to DONE.
- DONE (one cycle): done=1; error=1 only for IMM. Go to IDLE.
  - A start in this cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- Latency, counted from the start-capture edge to the done pulse:
  - IMM: done in cycle +1.
  - DIR / REG: strobe in cycle +1, done in cycle +2.
  - INDIR: PTR in cycle +1, strobe in cycle +2, done in cycle +3.
- Output holding:
  - Address and wdata outputs hold their last driven value outside WR/PTR.
  - Strobes are 0 outside WR.
  - ram_we and reg_we are never high together.
- Width rules:
  - Excess operand bits are ignored.
  - data_in is truncated or zero-extended to the destination data width.
- Back-to-back throughput: one request per 3 cycles for DIR/REG, 4 for INDIR, 2 for IMM.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 → busy=done=error=ram_we=reg_we=0, all addresses/data 0, no write.
- DIR: mode=01, operand=0x10, data=0xBB, start for 1 cycle → cycle+1 ram_we=1, ram_addr=0x10, ram_wdata=0xBB; cycle+2 done=1, error=0.
- INDIR: mode=10, operand=0x05, reg_rdata=0x20, data=0xCC →
  - cycle+1 reg_addr=0x5.
  - cycle+2 ram_we=1, ram_addr=0x20, ram_wdata=0xCC.
  - cycle+3 done=1.
- REG: mode=11, operand=0x17, data=0xDD → cycle+1 reg_we=1, reg_addr=0x7, reg_wdata=0xDD, ram_we=0; cycle+2 done=1.
- IMM: mode=00, operand=0xAA → cycle+1 done=1, error=1, no strobe at any time.
- Busy / reset boundary:
  - Issue a second start (DIR 0x30) during an INDIR store → ignored; only one ram_we, at 0x20.
  - Assert rst_n=0 during PTR of a new INDIR → no ram_we, no done, busy=0.
